// File: rtl/ped_signal.sv
// Pedestrian WALK / DONT_WALK head controller fed by the traffic_light lamp bus.
// Ports: clk, rst, leds[2:0], ped_req -> walk, dont_walk, req_pending, walk_left[7:0], fault.
module ped_signal #(
  parameter int WALK_TICKS  = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] leds,
  input  logic       ped_req,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [7:0] walk_left,
  output logic       fault
);

  typedef enum logic [2:0] {
    SOLID,
    DARK,
    WALK,
    FLASH,
    FAULT
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync;
  logic                   req_d;
  logic [2:0]             prev_leds;

  logic req_edge;
  logic green;
  logic onset;
  logic illegal;
  logic lamp_off;

  assign req_edge = sync[SYNC_STAGES-1] & ~req_d;
  assign green    = (leds == 3'b100);
  assign onset    = green && (prev_leds != 3'b100);
  assign illegal  = (leds[2] & leds[1]) |
                    (leds[2] & leds[0]) |
                    (leds[1] & leds[0]);
  assign lamp_off = (leds == 3'b000);

  // Button synchroniser, edge detector and lamp history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      req_d     <= 1'b0;
      prev_leds <= 3'b000;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], ped_req};
      req_d     <= sync[SYNC_STAGES-1];
      prev_leds <= leds;
    end
  end

  // Head FSM. Fault and dark checks take priority over the state.
  // dont_walk doubles as the flash phase while in FLASH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SOLID;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      walk_left   <= 8'd0;
      fault       <= 1'b0;
    end else if (state == FAULT) begin
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      walk_left <= 8'd0;
      fault     <= 1'b1;
    end else if (illegal) begin
      state     <= FAULT;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      walk_left <= 8'd0;
      fault     <= 1'b1;
    end else if (lamp_off) begin
      state       <= DARK;
      walk        <= 1'b0;
      dont_walk   <= 1'b0;
      walk_left   <= 8'd0;
      req_pending <= 1'b0;
    end else begin
      unique case (state)
        SOLID, DARK: begin
          if (onset && (req_pending || req_edge)) begin
            state       <= WALK;
            walk        <= 1'b1;
            dont_walk   <= 1'b0;
            walk_left   <= 8'(WALK_TICKS);
            req_pending <= 1'b0;
          end else begin
            state       <= SOLID;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            walk_left   <= 8'd0;
            req_pending <= req_pending | req_edge;
          end
        end
        WALK: begin
          if (!green) begin
            state     <= SOLID;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            walk_left <= 8'd0;
          end else if (walk_left == 8'd1) begin
            state     <= FLASH;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            walk_left <= 8'd0;
          end else begin
            walk      <= 1'b1;
            dont_walk <= 1'b0;
            walk_left <= walk_left - 8'd1;
          end
        end
        FLASH: begin
          req_pending <= req_pending | req_edge;
          walk        <= 1'b0;
          walk_left   <= 8'd0;
          if (!green) begin
            state     <= SOLID;
            dont_walk <= 1'b1;
          end else begin
            dont_walk <= ~dont_walk;
          end
        end
        default: begin
          state     <= FAULT;
          walk      <= 1'b0;
          dont_walk <= 1'b1;
          walk_left <= 8'd0;
          fault     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/ped_signal.md
Name: ped_signal

Overview:
- Pedestrian signal head controller that sits directly downstream of traffic_light.
- It consumes the vehicle lamp bus `leds` ([2]=green, [1]=yellow, [0]=red) and drives a parallel-crossing WALK / DONT_WALK head.
- Crossings are served only on request: WALK at green onset, flashing DONT_WALK for the rest of green, solid DONT_WALK through yellow/red.
- The head goes dark in attention/reset (leds=000) and latches a fault on an illegal lamp pattern. Clock is the same 2 Hz (0.5 s/tick) as traffic_light.

Parameters:
- WALK_TICKS, 14, length of WALK interval in clocks (7 s); legal range 1..255.
- SYNC_STAGES, 2, flops in the ped_req synchroniser; legal range ≥ 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- leds  input  3  vehicle lamp state from traffic_light, one-hot or 000.
- ped_req  input  1  asynchronous push-button, active-high, level.
- walk  output  1  WALK lamp.
- dont_walk  output  1  DONT_WALK lamp.
- req_pending  output  1  request latched, not yet served.
- walk_left  output  8  remaining WALK ticks; 0 outside WALK.
- fault  output  1  sticky illegal-lamp flag.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, sampled on rising clk. All outputs are registered.
- Reset values: walk=0, dont_walk=1, req_pending=0, walk_left=0, fault=0. Internal state: state=SOLID, prev_leds=000, synchroniser flops=0, flash phase=0.
- Reset mid-operation overrides everything in the same edge.
- Request path:
  - ped_req passes through SYNC_STAGES flops, then a rising-edge detector (one more flop).
  - req_pending sets on the (SYNC_STAGES+1)th rising edge after ped_req first samples high.
  - A held button counts once; release and re-press is required for another request.
- green_onset = (leds==100) && (prev_leds!=100); prev_leds is registered every cycle.
- illegal = more than one bit set in leds.
- States (evaluated in priority order each cycle):
  - Any state, illegal → FAULT.
    - fault=1, walk=0, dont_walk=1.
    - Stays in FAULT until rst; all inputs ignored.
  - leds==000 → DARK.
    - walk=0, dont_walk=0, walk_left=0.
    - req_pending cleared; request edges are ignored while in DARK.
  - SOLID/DARK, green_onset:
    - With req_pending=1, or a request edge in the same cycle → WALK. Set walk_left=WALK_TICKS and clear req_pending.
    - Otherwise → SOLID (dont_walk=1 for the whole green).
  - WALK: walk=1, dont_walk=0; walk_left decrements each cycle.
    - Request edges are absorbed, since they are already served.
    - leds!=100 → SOLID immediately (early clearance), walk_left=0.
    - walk_left==1 and still green → FLASH, walk_left=0.
    - WALK therefore lasts exactly WALK_TICKS cycles when green persists.
  - FLASH: walk=0; dont_walk=1 on the first FLASH cycle, then toggles every cycle (period 2 ticks = 1 s).
    - Request edges set req_pending.
    - leds!=100 → SOLID (dont_walk=1) or DARK (leds=000).
  - SOLID: walk=0, dont_walk=1.
    - Request edges set req_pending.
    - Remains in SOLID while leds is 010 or 001.
- Latency: a change on leds is reflected on the outputs at the next rising edge (1 cycle).
- walk and dont_walk are never both 1.

Test Plan:
- Reset, then leds=001 for 4 clks, then leds=100 with no request → walk=0, dont_walk=1 throughout green; req_pending=0.
- Pulse ped_req 1 clk during red (leds=001) → req_pending=1 three edges later. leds→100 → next cycle walk=1, walk_left=14, req_pending=0. After 14 WALK cycles: FLASH with dont_walk pattern 1,0,1,0… until leds→010 → dont_walk=1 solid.
- Request pending, green lasts only 5 clks → walk=1 for 5 cycles (walk_left 14..10), then SOLID with dont_walk=1 on the cycle after leds=010.
- Press during WALK → no req_pending. Press during FLASH → req_pending=1, served at the next green onset.
- Attention pattern leds 000/010 alternating → DARK (both lamps 0) on 000 cycles and SOLID on 010 cycles; req_pending stays 0 after a press during 000. Exit to 100 counts as green_onset.
- leds=110 for 1 clk → fault=1, dont_walk=1; later legal leds and ped_req have no effect. rst → fault=0, dont_walk=1.
